// File: rtl/vec_dcache_arbiter.sv
// Round-robin arbiter merging a scalar LSU and a vector accelerator onto one dcache port.
// Define VEC_DCACHE_ARB_FLUSH_EN to add the flush_i/flush_done_o drain mode.
module vec_dcache_arbiter #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_req_i,
    input  logic                   s_we_i,
    input  logic [AddrWidth-1:0]   s_addr_i,
    input  logic [DataWidth-1:0]   s_wdata_i,
    input  logic [DataWidth/8-1:0] s_be_i,
    output logic                   s_gnt_o,
    output logic                   s_rvalid_o,
    output logic [DataWidth-1:0]   s_rdata_o,
    input  logic                   a_req_i,
    input  logic                   a_we_i,
    input  logic [AddrWidth-1:0]   a_addr_i,
    input  logic [DataWidth-1:0]   a_wdata_i,
    input  logic [DataWidth/8-1:0] a_be_i,
    output logic                   a_gnt_o,
    output logic                   a_rvalid_o,
    output logic [DataWidth-1:0]   a_rdata_o,
    output logic                   m_req_o,
    output logic                   m_we_o,
    output logic [AddrWidth-1:0]   m_addr_o,
    output logic [DataWidth-1:0]   m_wdata_o,
    output logic [DataWidth/8-1:0] m_be_o,
    input  logic                   m_gnt_i,
    input  logic                   m_rvalid_i,
    input  logic [DataWidth-1:0]   m_rdata_i,
    output logic [3:0]             outstanding_o
`ifdef VEC_DCACHE_ARB_FLUSH_EN
    ,
    input  logic                   flush_i,
    output logic                   flush_done_o
`endif
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [MaxOutstanding-1:0] r_owner;
    logic [PtrW-1:0]           r_wptr;
    logic [PtrW-1:0]           r_rptr;
    logic [3:0]                r_count;
    logic                      r_rr;
    logic                      r_locked;
    logic                      r_lock_sel;
    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;

    logic w_full;
    logic w_drain;
    logic w_sel;
    logic w_sel_req;
    logic w_push;
    logic w_pop;
    logic w_head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == 4'(MaxOutstanding));
    assign w_drain = (r_state == StDrain);

    // w_sel: 0 = scalar, 1 = accelerator; r_rr names the requester favoured on a tie
    always_comb begin
        w_sel = 1'b0;
        if (r_locked) begin
            w_sel = r_lock_sel;
        end else if (s_req_i && a_req_i) begin
            w_sel = r_rr;
        end else begin
            w_sel = a_req_i;
        end
    end

    assign w_sel_req = w_sel ? a_req_i : s_req_i;
    assign m_req_o   = rst_ni & w_sel_req & ~w_full & ~w_drain;
    assign m_we_o    = w_sel ? a_we_i    : s_we_i;
    assign m_addr_o  = w_sel ? a_addr_i  : s_addr_i;
    assign m_wdata_o = w_sel ? a_wdata_i : s_wdata_i;
    assign m_be_o    = w_sel ? a_be_i    : s_be_i;

    assign w_push  = m_req_o & m_gnt_i;
    assign s_gnt_o = w_push & ~w_sel;
    assign a_gnt_o = w_push & w_sel;

    assign w_pop      = m_rvalid_i & (r_count != 4'd0);
    assign w_head     = r_owner[r_rptr];
    assign s_rvalid_o = w_pop & ~w_head;
    assign a_rvalid_o = w_pop & w_head;
    assign s_rdata_o  = m_rdata_i;
    assign a_rdata_o  = m_rdata_i;

    assign outstanding_o = r_count;

`ifdef VEC_DCACHE_ARB_FLUSH_EN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StRun:   if (flush_i)  w_state_nxt = StDrain;
            StDrain: if (!flush_i) w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    assign flush_done_o = w_drain & (r_count == 4'd0);
`else
    assign w_state_nxt = StRun;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= 4'd0;
            r_rr       <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_sel <= 1'b0;
            r_state    <= StRun;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_wptr          <= ptr_inc(r_wptr);
                r_rr            <= ~w_sel;
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            // Lock survives a drain so the stalled requester resumes with the same choice
            if (w_push) begin
                r_locked <= 1'b0;
            end else if (m_req_o) begin
                r_locked   <= 1'b1;
                r_lock_sel <= w_sel;
            end
        end
    end

endmodule

// File: tb/tb_vec_dcache_arbiter.sv
// Scoreboard bench for vec_dcache_arbiter: directed stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them.
module tb_vec_dcache_arbiter;

    typedef struct packed {
        logic        own;
        logic [63:0] val;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_req_i, s_we_i, a_req_i, a_we_i;
    logic [63:0] s_addr_i, s_wdata_i, a_addr_i, a_wdata_i;
    logic [7:0]  s_be_i, a_be_i;
    logic        s_gnt_o, s_rvalid_o, a_gnt_o, a_rvalid_o;
    logic [63:0] s_rdata_o, a_rdata_o;
    logic        m_req_o, m_we_o;
    logic [63:0] m_addr_o, m_wdata_o;
    logic [7:0]  m_be_o;
    logic        m_gnt_i, m_rvalid_i;
    logic [63:0] m_rdata_i;
    logic [3:0]  outstanding_o;
`ifdef VEC_DCACHE_ARB_FLUSH_EN
    logic        flush_i;
    logic        flush_done_o;
`endif

    exp_t exp_g[$];
    exp_t exp_r[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    vec_dcache_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .s_req_i      (s_req_i),
        .s_we_i       (s_we_i),
        .s_addr_i     (s_addr_i),
        .s_wdata_i    (s_wdata_i),
        .s_be_i       (s_be_i),
        .s_gnt_o      (s_gnt_o),
        .s_rvalid_o   (s_rvalid_o),
        .s_rdata_o    (s_rdata_o),
        .a_req_i      (a_req_i),
        .a_we_i       (a_we_i),
        .a_addr_i     (a_addr_i),
        .a_wdata_i    (a_wdata_i),
        .a_be_i       (a_be_i),
        .a_gnt_o      (a_gnt_o),
        .a_rvalid_o   (a_rvalid_o),
        .a_rdata_o    (a_rdata_o),
        .m_req_o      (m_req_o),
        .m_we_o       (m_we_o),
        .m_addr_o     (m_addr_o),
        .m_wdata_o    (m_wdata_o),
        .m_be_o       (m_be_o),
        .m_gnt_i      (m_gnt_i),
        .m_rvalid_i   (m_rvalid_i),
        .m_rdata_i    (m_rdata_i),
        .outstanding_o(outstanding_o)
`ifdef VEC_DCACHE_ARB_FLUSH_EN
        ,
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_g(input logic own, input logic [63:0] addr);
        exp_g.push_back('{own: own, val: addr});
    endtask

    task automatic push_r(input logic own, input logic [63:0] data);
        exp_r.push_back('{own: own, val: data});
    endtask

    // Monitor: every grant and response the DUT presents must match the queue head
    always @(negedge clk_i) begin
        exp_t e;
        if (s_gnt_o || a_gnt_o) begin
            if (exp_g.size() == 0) begin
                chk("unexpected_gnt", 64'(s_gnt_o | a_gnt_o), 64'd0);
            end else begin
                e = exp_g.pop_front();
                chk("gnt_owner_a", 64'(a_gnt_o), 64'(e.own));
                chk("gnt_owner_s", 64'(s_gnt_o), 64'(!e.own));
                chk("gnt_addr", m_addr_o, e.val);
            end
        end
        if (s_rvalid_o || a_rvalid_o) begin
            if (exp_r.size() == 0) begin
                chk("unexpected_rvalid", 64'(s_rvalid_o | a_rvalid_o), 64'd0);
            end else begin
                e = exp_r.pop_front();
                chk("rsp_owner_a", 64'(a_rvalid_o), 64'(e.own));
                chk("rsp_owner_s", 64'(s_rvalid_o), 64'(!e.own));
                chk("rsp_data", e.own ? a_rdata_o : s_rdata_o, e.val);
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        s_req_i = 1'b1; a_req_i = 1'b1; s_we_i = 1'b0; a_we_i = 1'b0;
        s_addr_i = '0; a_addr_i = '0; s_wdata_i = '0; a_wdata_i = '0;
        s_be_i = 8'hFF; a_be_i = 8'hFF;
        m_gnt_i = 1'b1; m_rvalid_i = 1'b0; m_rdata_i = '0;
`ifdef VEC_DCACHE_ARB_FLUSH_EN
        flush_i = 1'b0;
`endif
        #3;
        chk("rst_m_req", 64'(m_req_o), 64'd0);
        chk("rst_gnt", 64'(s_gnt_o | a_gnt_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        step();
        step();
        rst_ni = 1'b1;

        // Both requesting continuously, responses one cycle after each grant
        s_addr_i = 64'h100; a_addr_i = 64'h200;
        for (int i = 0; i < 6; i++) begin
            m_rvalid_i = (i > 0);
            m_rdata_i  = 64'h1000 + 64'(i) - 64'd1;
            push_g(i[0], i[0] ? 64'h200 : 64'h100);
            if (i > 0) push_r(!i[0], m_rdata_i);
            step();
        end
        s_req_i = 1'b0; a_req_i = 1'b0; m_gnt_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'h1005; push_r(1'b1, 64'h1005);
        step();
        m_rvalid_i = 1'b0;
        #2 chk("alt_outstanding", 64'(outstanding_o), 64'd0);

        // Lock: A stalls ungranted, S arrives later and must not steal the port
        a_req_i = 1'b1; a_we_i = 1'b1; a_addr_i = 64'h300; a_wdata_i = 64'hA5A5; a_be_i = 8'h0F;
        s_addr_i = 64'h400;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) s_req_i = 1'b1;
            #2;
            chk("lock_addr", m_addr_o, 64'h300);
            chk("lock_req", 64'(m_req_o), 64'd1);
            if (i == 4) begin
                chk("lock_wdata", m_wdata_o, 64'hA5A5);
                chk("lock_be", 64'(m_be_o), 64'h0F);
                chk("lock_we", 64'(m_we_o), 64'd1);
            end
            step();
        end
        m_gnt_i = 1'b1; push_g(1'b1, 64'h300);
        step();
        a_req_i = 1'b0; a_we_i = 1'b0; push_g(1'b0, 64'h400);
        step();
        s_req_i = 1'b0; m_gnt_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'h2000; push_r(1'b1, 64'h2000);
        step();
        m_rdata_i = 64'h2001; push_r(1'b0, 64'h2001);
        step();
        m_rvalid_i = 1'b0;

        // Fill to MaxOutstanding, then one response frees a slot
        s_req_i = 1'b1; m_gnt_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_addr_i = 64'h500 + 64'(i);
            push_g(1'b0, s_addr_i);
            step();
        end
        s_addr_i = 64'h507;
        #2;
        chk("full_outstanding", 64'(outstanding_o), 64'd7);
        chk("full_m_req", 64'(m_req_o), 64'd0);
        step();
        m_rvalid_i = 1'b1; m_rdata_i = 64'h3000; push_r(1'b0, 64'h3000);
        #2 chk("full_pop_m_req", 64'(m_req_o), 64'd0);
        step();
        m_rvalid_i = 1'b0;
        #2;
        chk("after_pop_outstanding", 64'(outstanding_o), 64'd6);
        chk("after_pop_m_req", 64'(m_req_o), 64'd1);
        push_g(1'b0, 64'h507);
        step();
        s_req_i = 1'b0; m_gnt_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            m_rvalid_i = 1'b1; m_rdata_i = 64'h3000 + 64'(i);
            push_r(1'b0, m_rdata_i);
            step();
        end
        m_rvalid_i = 1'b0;
        #2 chk("drained_outstanding", 64'(outstanding_o), 64'd0);

        // Stray response with nothing outstanding
        step();
        m_rvalid_i = 1'b1; m_rdata_i = 64'hDEAD;
        #2;
        chk("stray_s_rvalid", 64'(s_rvalid_o), 64'd0);
        chk("stray_a_rvalid", 64'(a_rvalid_o), 64'd0);
        step();
        m_rvalid_i = 1'b0;
        #2 chk("stray_outstanding", 64'(outstanding_o), 64'd0);

        // Reset with 4 outstanding A transactions
        a_req_i = 1'b1; m_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr_i = 64'h600 + 64'(i);
            push_g(1'b1, a_addr_i);
            step();
        end
        a_req_i = 1'b0; m_gnt_i = 1'b0;
        #1 chk("pre_rst_outstanding", 64'(outstanding_o), 64'd4);
        rst_ni = 1'b0;
        #1 chk("mid_rst_outstanding", 64'(outstanding_o), 64'd0);
        s_req_i = 1'b1; a_req_i = 1'b1; m_gnt_i = 1'b1; a_addr_i = 64'h700; s_addr_i = 64'h800;
        #1 chk("mid_rst_m_req", 64'(m_req_o), 64'd0);
        step();
        step();
        rst_ni = 1'b1; push_g(1'b0, 64'h800);
        step();
        push_g(1'b1, 64'h700);
        step();
        s_req_i = 1'b0; a_req_i = 1'b0; m_gnt_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'h4000; push_r(1'b0, 64'h4000);
        step();
        m_rdata_i = 64'h4001; push_r(1'b1, 64'h4001);
        step();
        m_rvalid_i = 1'b0;

`ifdef VEC_DCACHE_ARB_FLUSH_EN
        // Flush: drain 3 outstanding, no new grants, done after last response
        s_req_i = 1'b1; m_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_addr_i = 64'h900 + 64'(i);
            push_g(1'b0, s_addr_i);
            step();
        end
        s_req_i = 1'b0; flush_i = 1'b1;
        step();
        s_req_i = 1'b1; a_req_i = 1'b1; a_addr_i = 64'hA00;
        #2;
        chk("flush_m_req", 64'(m_req_o), 64'd0);
        chk("flush_done_busy", 64'(flush_done_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            m_rvalid_i = 1'b1; m_rdata_i = 64'h5000 + 64'(i);
            push_r(1'b0, m_rdata_i);
            step();
        end
        m_rvalid_i = 1'b0;
        #2;
        chk("flush_done", 64'(flush_done_o), 64'd1);
        chk("flush_m_req_idle", 64'(m_req_o), 64'd0);
        flush_i = 1'b0;
        step();
        push_g(1'b1, 64'hA00);
        step();
        s_req_i = 1'b0; a_req_i = 1'b0; m_gnt_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'h5100; push_r(1'b1, 64'h5100);
        step();
        m_rvalid_i = 1'b0;
`endif

        step();
        step();
        chk("grants_left", 64'(exp_g.size()), 64'd0);
        chk("responses_left", 64'(exp_r.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
